// File: rtl/mant_div_param_pkg.sv
// ----------------------------------------------------------------------------
// fp_div_pkg
// Shared definitions for the parameterised mantissa divider:
//   - state_t     : controller state encoding (IDLE / RUN / DONE)
//   - *_DEF       : default mantissa width, quotient width, bits per cycle
//   - cnt_width() : width of the step counter, clog2(Q_W/R + 1)
// ----------------------------------------------------------------------------
package fp_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MANT_W_DEF = 24;
    localparam int Q_W_DEF    = 26;
    localparam int R_DEF      = 1;

    // Counter must hold the value Q_W/R loaded at accept.
    function automatic int cnt_width(input int q_w, input int r);
        return $clog2(q_w / r + 1);
    endfunction

endpackage

// File: rtl/mant_div_param_div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   in_p  [MANT_W:0]   partial remainder
//   in_d  [MANT_W-1:0] divisor
//   out_q              quotient bit (in_p >= in_d)
//   out_p [MANT_W:0]   next partial remainder, (q ? P-D : P) << 1, truncated
// ----------------------------------------------------------------------------
module div_step #(
    parameter int MANT_W = 24
) (
    input  logic [MANT_W:0]   in_p,
    input  logic [MANT_W-1:0] in_d,
    output logic              out_q,
    output logic [MANT_W:0]   out_p
);

    logic [MANT_W:0] w_d_ext;
    logic [MANT_W:0] w_diff;
    logic [MANT_W:0] w_sel;

    assign w_d_ext = {1'b0, in_d};
    assign out_q   = (in_p >= w_d_ext);
    assign w_diff  = in_p - w_d_ext;
    assign w_sel   = out_q ? w_diff : in_p;
    // Left shift drops the MSB; with P < 2*D it is always zero here.
    assign out_p   = w_sel << 1;

endmodule

// File: rtl/mant_div_param.sv
// ----------------------------------------------------------------------------
// mant_div_param
// Iterative restoring mantissa divider retiring R quotient bits per cycle.
// Ports:
//   in_Clk, in_Rst                 clock, async active-high reset
//   in_req_valid / out_req_ready   operand handshake (ready only in IDLE)
//   in_dividend [MANT_W:0]         dividend mantissa
//   in_divisor  [MANT_W-1:0]       divisor mantissa (MSB expected set)
//   in_abort                       synchronous cancel, highest priority
//   out_rsp_valid / in_rsp_ready   result handshake (valid held in DONE)
//   out_quotient [Q_W-1:0]         quotient, first-generated bit is MSB
//   out_remainder [MANT_W:0]       final partial remainder
//   out_sticky                     |remainder (forced 1 on divide-by-zero)
//   out_div_zero                   divisor was zero
// ----------------------------------------------------------------------------
module mant_div_param
    import fp_div_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int Q_W    = Q_W_DEF,
    parameter int R      = R_DEF
) (
    input  logic              in_Clk,
    input  logic              in_Rst,
    input  logic              in_req_valid,
    output logic              out_req_ready,
    input  logic [MANT_W:0]   in_dividend,
    input  logic [MANT_W-1:0] in_divisor,
    input  logic              in_abort,
    output logic              out_rsp_valid,
    input  logic              in_rsp_ready,
    output logic [Q_W-1:0]    out_quotient,
    output logic [MANT_W:0]   out_remainder,
    output logic              out_sticky,
    output logic              out_div_zero
);

    localparam int CNT_W = cnt_width(Q_W, R);
    localparam int STEPS = Q_W / R;

    generate
        if ((R != 1 && R != 2) || (Q_W % R) != 0) begin : g_param_chk
            $error("mant_div_param: R must be 1 or 2 and divide Q_W");
        end
    endgenerate

    state_t            r_state;
    logic [MANT_W:0]   r_p;
    logic [MANT_W-1:0] r_d;
    logic [Q_W-1:0]    r_q;
    logic [CNT_W-1:0]  r_cnt;

    logic [MANT_W:0]   w_p [0:R];
    logic [R-1:0]      w_qbits;
    logic              w_d_zero;

    // Chain of R single-bit steps; step 0 yields the most significant bit.
    assign w_p[0] = r_p;
    generate
        for (genvar k = 0; k < R; k++) begin : g_step
            div_step #(.MANT_W(MANT_W)) u_step (
                .in_p  (w_p[k]),
                .in_d  (r_d),
                .out_q (w_qbits[R-1-k]),
                .out_p (w_p[k+1])
            );
        end
    endgenerate

    // Controller and datapath registers.
    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            r_state <= ST_IDLE;
            r_p     <= '0;
            r_d     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
        end else if (in_abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_req_valid) begin
                        r_d     <= in_divisor;
                        r_p     <= in_dividend;
                        r_state <= ST_RUN;
                        if (in_divisor == '0) begin
                            // Divide-by-zero: one pass-through cycle, no steps,
                            // remainder keeps the dividend.
                            r_q   <= '1;
                            r_cnt <= CNT_W'(1);
                        end else begin
                            r_q   <= '0;
                            r_cnt <= CNT_W'(STEPS);
                        end
                    end
                end
                ST_RUN: begin
                    if (!w_d_zero) begin
                        r_p <= w_p[R];
                        r_q <= {r_q[Q_W-R-1:0], w_qbits};
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                    // "<=" rather than "==" so a corrupted count cannot hang.
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (in_rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_d_zero      = (r_d == '0);
    assign out_req_ready = (r_state == ST_IDLE);
    assign out_rsp_valid = (r_state == ST_DONE);
    assign out_quotient  = r_q;
    assign out_remainder = r_p;
    assign out_div_zero  = out_rsp_valid & w_d_zero;
    assign out_sticky    = (|r_p) | out_div_zero;

endmodule

// File: tb/tb_mant_div_param.sv
// ----------------------------------------------------------------------------
// tb_mant_div_param
// Directed + light random bench for mant_div_param. Two instances: R=1 (idx 0)
// and R=2 (idx 1). Expected results come from an integer reference model
// (long division of dividend * 2^(Q_W-1) by divisor) pushed to a scoreboard
// at request time and popped when the response appears.
// ----------------------------------------------------------------------------
module tb_mant_div_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid [2];
    logic        abort_s   [2];
    logic        rsp_ready [2];
    logic [24:0] dividend  [2];
    logic [23:0] divisor   [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [25:0] quotient  [2];
    logic [24:0] remainder [2];
    logic        sticky    [2];
    logic        div_zero  [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [25:0] q;
        logic [24:0] rem;
        logic        st;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb [$];

    mant_div_param #(.MANT_W(24), .Q_W(26), .R(1)) dut_r1 (
        .in_Clk        (clk),
        .in_Rst        (rst),
        .in_req_valid  (req_valid[0]),
        .out_req_ready (req_ready[0]),
        .in_dividend   (dividend[0]),
        .in_divisor    (divisor[0]),
        .in_abort      (abort_s[0]),
        .out_rsp_valid (rsp_valid[0]),
        .in_rsp_ready  (rsp_ready[0]),
        .out_quotient  (quotient[0]),
        .out_remainder (remainder[0]),
        .out_sticky    (sticky[0]),
        .out_div_zero  (div_zero[0])
    );

    mant_div_param #(.MANT_W(24), .Q_W(26), .R(2)) dut_r2 (
        .in_Clk        (clk),
        .in_Rst        (rst),
        .in_req_valid  (req_valid[1]),
        .out_req_ready (req_ready[1]),
        .in_dividend   (dividend[1]),
        .in_divisor    (divisor[1]),
        .in_abort      (abort_s[1]),
        .out_rsp_valid (rsp_valid[1]),
        .in_rsp_ready  (rsp_ready[1]),
        .out_quotient  (quotient[1]),
        .out_remainder (remainder[1]),
        .out_sticky    (sticky[1]),
        .out_div_zero  (div_zero[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [24:0] dvd, input logic [23:0] dvs, input int steps);
        exp_t        e;
        logic [63:0] num;
        logic [63:0] qq;
        logic [63:0] rr;
        if (dvs == 24'd0) begin
            e.q   = '1;
            e.rem = dvd;
            e.st  = 1'b1;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            num   = {39'd0, dvd} << 25;
            qq    = num / {40'd0, dvs};
            rr    = num % {40'd0, dvs};
            e.q   = qq[25:0];
            e.rem = {rr[23:0], 1'b0};
            e.st  = (rr != 64'd0);
            e.dz  = 1'b0;
            e.lat = steps;
        end
        return e;
    endfunction

    // Full transaction: request, latency, result, hold in DONE, release.
    task automatic run_div(input int u, input logic [24:0] dvd, input logic [23:0] dvs,
                           input int hold, input string tag);
        exp_t e;
        int   lat;
        @(negedge clk);
        check({tag, "/req_ready"}, {63'd0, req_ready[u]}, 64'd1);
        req_valid[u] = 1'b1;
        dividend[u]  = dvd;
        divisor[u]   = dvs;
        sb.push_back(model(dvd, dvs, (u == 0) ? 26 : 13));
        @(negedge clk);
        req_valid[u] = 1'b0;
        dividend[u]  = 25'($urandom);
        divisor[u]   = 24'($urandom);
        lat = 0;
        while (rsp_valid[u] !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check({tag, "/latency"},   64'(lat),                 64'(e.lat));
        check({tag, "/quotient"},  {38'd0, quotient[u]},     {38'd0, e.q});
        check({tag, "/remainder"}, {39'd0, remainder[u]},    {39'd0, e.rem});
        check({tag, "/sticky"},    {63'd0, sticky[u]},       {63'd0, e.st});
        check({tag, "/div_zero"},  {63'd0, div_zero[u]},     {63'd0, e.dz});
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({tag, "/hold_valid"},    {63'd0, rsp_valid[u]},  64'd1);
            check({tag, "/hold_req_rdy"},  {63'd0, req_ready[u]},  64'd0);
            check({tag, "/hold_quotient"}, {38'd0, quotient[u]},   {38'd0, e.q});
            check({tag, "/hold_rem"},      {39'd0, remainder[u]},  {39'd0, e.rem});
        end
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        check({tag, "/rel_valid"},   {63'd0, rsp_valid[u]}, 64'd0);
        check({tag, "/rel_req_rdy"}, {63'd0, req_ready[u]}, 64'd1);
    endtask

    // Start a division, cancel it at RUN cycle 5 by abort or reset.
    task automatic cancel_mid(input int u, input bit use_reset, input string tag);
        int seen;
        @(negedge clk);
        req_valid[u] = 1'b1;
        dividend[u]  = 25'h0C00000;
        divisor[u]   = 24'h800000;
        @(negedge clk);
        req_valid[u] = 1'b0;
        repeat (4) @(negedge clk);
        if (use_reset) begin
            rst = 1'b1;
            #1;
            check({tag, "/rst_quotient"}, {38'd0, quotient[u]},  64'd0);
            check({tag, "/rst_rem"},      {39'd0, remainder[u]}, 64'd0);
            check({tag, "/rst_sticky"},   {63'd0, sticky[u]},    64'd0);
            check({tag, "/rst_dz"},       {63'd0, div_zero[u]},  64'd0);
            check({tag, "/rst_valid"},    {63'd0, rsp_valid[u]}, 64'd0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end else begin
            abort_s[u] = 1'b1;
            @(negedge clk);
            abort_s[u] = 1'b0;
        end
        check({tag, "/req_ready"}, {63'd0, req_ready[u]}, 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid[u] !== 1'b0) seen++;
        end
        check({tag, "/no_rsp"}, 64'(seen), 64'd0);
    endtask

    initial begin
        int          seen;
        logic [23:0] rd;
        logic [24:0] rn;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            abort_s[i]   = 1'b0;
            rsp_ready[i] = 1'b0;
            dividend[i]  = 25'd0;
            divisor[i]   = 24'd0;
        end

        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset/quotient",  {38'd0, quotient[i]},  64'd0);
            check("reset/remainder", {39'd0, remainder[i]}, 64'd0);
            check("reset/sticky",    {63'd0, sticky[i]},    64'd0);
            check("reset/div_zero",  {63'd0, div_zero[i]},  64'd0);
            check("reset/rsp_valid", {63'd0, rsp_valid[i]}, 64'd0);
            check("reset/req_ready", {63'd0, req_ready[i]}, 64'd1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_div(0, 25'h0800000, 24'h800000, 0,  "r1_1_over_1");
        run_div(0, 25'h0C00000, 24'h800000, 0,  "r1_1p5");
        run_div(1, 25'h0C00000, 24'h800000, 0,  "r2_1p5");
        run_div(0, 25'h0800000, 24'hC00000, 10, "r1_2_3_hold");
        run_div(1, 25'h0800000, 24'hC00000, 0,  "r2_2_3");
        run_div(0, 25'h0800000, 24'h000000, 0,  "r1_dz");
        run_div(1, 25'h0800000, 24'h000000, 3,  "r2_dz");
        run_div(1, 25'h17FFFFF, 24'hC00000, 0,  "r2_near_max");

        cancel_mid(0, 1'b0, "r1_abort");
        run_div(0, 25'h0C00000, 24'h800000, 0, "r1_after_abort");
        cancel_mid(0, 1'b1, "r1_reset");
        run_div(0, 25'h0800000, 24'hC00000, 0, "r1_after_reset");
        cancel_mid(1, 1'b0, "r2_abort");
        run_div(1, 25'h0800000, 24'h800000, 0, "r2_after_abort");

        // Abort together with a request: no accept.
        @(negedge clk);
        req_valid[0] = 1'b1;
        abort_s[0]   = 1'b1;
        dividend[0]  = 25'h0800000;
        divisor[0]   = 24'h800000;
        @(negedge clk);
        req_valid[0] = 1'b0;
        abort_s[0]   = 1'b0;
        seen = 0;
        repeat (30) begin
            if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) seen++;
            @(negedge clk);
        end
        check("abort_vs_accept/idle", 64'(seen), 64'd0);

        // Abort while in DONE drops the pending result.
        @(negedge clk);
        req_valid[1] = 1'b1;
        dividend[1]  = 25'h0123456;
        divisor[1]   = 24'h000000;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("abort_done/valid_before", {63'd0, rsp_valid[1]}, 64'd1);
        abort_s[1] = 1'b1;
        @(negedge clk);
        abort_s[1] = 1'b0;
        check("abort_done/valid_after", {63'd0, rsp_valid[1]}, 64'd0);
        check("abort_done/req_ready",   {63'd0, req_ready[1]}, 64'd1);

        // Random legal operands: divisor MSB set, dividend < 2*divisor.
        for (int n = 0; n < 6; n++) begin
            rd = {1'b1, 23'($urandom)};
            rn = 25'($urandom_range(2 * int'(rd) - 1, 0));
            run_div(n % 2, rn, rd, 0, (n % 2 == 0) ? "r1_rand" : "r2_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mant_div_param.md
MANT_DIV_PARAM -- requirements
Module: mant_div_param

Interface
REQ-001 Parameter MANT_W, default 24, mantissa width including hidden bit.
REQ-002 Parameter Q_W, default 26, quotient bits produced (MANT_W + guard + round).
REQ-003 Parameter R, default 1, quotient bits retired per cycle; legal 1, 2; Q_W % R == 0 SHALL hold (elaboration error otherwise).
REQ-004 in_Clk  input  1  sole clock, rising edge.
REQ-005 in_Rst  input  1  reset, asynchronous, active-high.
REQ-006 in_req_valid  input  1  operands valid.
REQ-007 out_req_ready  output  1  block can accept operands.
REQ-008 in_dividend  input  MANT_W+1  dividend mantissa.
REQ-009 in_divisor  input  MANT_W  divisor mantissa.
REQ-010 in_abort  input  1  synchronous cancel of any operation.
REQ-011 out_rsp_valid  output  1  result valid.
REQ-012 in_rsp_ready  input  1  consumer accepts result.
REQ-013 out_quotient  output  Q_W  quotient bits, MSB first-generated.
REQ-014 out_remainder  output  MANT_W+1  final partial remainder.
REQ-015 out_sticky  output  1  OR-reduction of final remainder.
REQ-016 out_div_zero  output  1  divisor was zero.

Function
REQ-017 States IDLE, RUN, DONE; out_req_ready = (state==IDLE).
REQ-018 Accept on edge with in_req_valid & out_req_ready & !in_abort: latch divisor D, set partial remainder P = dividend, clear quotient, counter = Q_W/R, go RUN.
REQ-019 Per bit step: q = (P >= D); P = (q ? P-D : P) << 1, truncated to MANT_W+1 bits; q shifted into quotient LSB; R steps chained combinationally per cycle.
REQ-020 Operand precondition: D MSB set and dividend < 2*D; under it P < 2*D always and no overflow occurs; violation yields unspecified quotient, no hang.
REQ-021 RUN lasts exactly Q_W/R cycles; out_rsp_valid rises on the Q_W/R-th edge after the accept edge; then DONE.
REQ-022 DONE holds out_rsp_valid and all result outputs stable until edge with in_rsp_ready=1, then IDLE; no new accept on that same edge.
REQ-023 out_sticky = |out_remainder, valid whenever out_rsp_valid.
REQ-024 Divisor zero at accept: skip RUN, enter DONE next edge, out_quotient all ones, out_remainder = dividend, out_div_zero=1, out_sticky=1.
REQ-025 out_div_zero=0 for every non-zero divisor result.
REQ-026 in_abort=1 in any state: next edge IDLE, out_rsp_valid=0, result discarded; abort beats simultaneous accept or rsp handshake.
REQ-027 Operand inputs ignored outside the accept edge.

Reset
REQ-028 in_Rst=1 immediately forces IDLE, out_rsp_valid=0, out_quotient=0, out_remainder=0, out_sticky=0, out_div_zero=0, counter=0.
REQ-029 Reset mid-RUN or mid-DONE discards the operation; out_req_ready=1 from first edge after deassertion.

Structure
REQ-030 Package fp_div_pkg SHALL hold state enum type, default MANT_W/Q_W/R constants, and counter width function clog2(Q_W/R+1).
REQ-031 One sub-module div_step: combinational single-bit restoring step (P, D -> q, P'), instantiated R times in a generate chain.
REQ-032 Datapath registers P, D, quotient, counter; no other storage.

Verification
REQ-033 Dividend 0x0800000, divisor 0x800000, R=1 -> after 26 cycles quotient 0x2000000, remainder 0, sticky 0, div_zero 0.
REQ-034 Dividend 0x0C00000, divisor 0x800000 -> quotient 0x3000000, sticky 0; R=2 run gives identical result after 13 cycles.
REQ-035 Dividend 0x0800000, divisor 0xC00000 -> quotient 0x1555555, sticky 1.
REQ-036 Divisor 0, dividend 0x0800000 -> rsp valid 1 cycle after accept, quotient 0x3FFFFFF, div_zero 1, sticky 1.
REQ-037 in_rsp_ready held low 10 cycles in DONE -> outputs stable, req_ready 0; then ready 1 -> IDLE next edge.
REQ-038 in_abort at RUN cycle 5, and in_Rst at RUN cycle 5 -> IDLE, no rsp_valid pulse; following division correct.
